// File: rtl/t1_watchdog_pkg.sv
// rtl/t1_watchdog_pkg.sv - shared state encoding and status codes for the retire watchdog
package t1_watchdog_pkg;

    typedef enum logic [1:0] {
        WD_RUN   = 2'd0,
        WD_DRAIN = 2'd1,
        WD_DONE  = 2'd2,
        WD_FAIL  = 2'd3
    } wd_state_t;

    localparam logic [7:0] ST_RUN       = 8'd0;
    localparam logic [7:0] ST_OK        = 8'd255;
    localparam logic [7:0] ST_RETIRE_TO = 8'd1;
    localparam logic [7:0] ST_GLOBAL_TO = 8'd2;
    localparam logic [7:0] ST_DRAIN_TO  = 8'd3;

    function automatic logic wd_is_active(input wd_state_t s);
        return (s == WD_RUN) || (s == WD_DRAIN);
    endfunction

endpackage

// File: rtl/t1_sat_counter.sv
// rtl/t1_sat_counter.sv - saturating up-counter with synchronous clear and enable
module t1_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/t1_retire_watchdog.sv
// rtl/t1_retire_watchdog.sv - retire/global/drain watchdog producing a sticky run status
module t1_retire_watchdog
    import t1_watchdog_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DRAIN_LIMIT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] timeout_cfg,
    input  logic [CNT_W-1:0] global_timeout_cfg,
    input  logic             retire_valid,
    input  logic             finish_req,
    input  logic [7:0]       outstanding,
    output logic [7:0]       status,
    output logic [CNT_W-1:0] cycle,
    output logic [CNT_W-1:0] retired
);

    // A limit wider than the drain counter can never be reached by it.
    localparam bit              DRAIN_LIMIT_FITS = (DRAIN_LIMIT > 0) &&
                                                   ($clog2(DRAIN_LIMIT + 1) <= CNT_W + 1);
    localparam logic [CNT_W:0]  DRAIN_LIMIT_W    = (CNT_W + 1)'(DRAIN_LIMIT);

    wd_state_t        state;
    wd_state_t        state_nxt;
    logic [7:0]       status_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] drain_cnt;
    logic             active;
    logic             in_run;
    logic             in_drain;
    logic             global_to;
    logic             retire_to;
    logic             drain_to;

    // Compares are done one bit wider so a saturated counter never wraps into a match.
    logic [CNT_W:0]   cycle_inc;
    logic [CNT_W:0]   idle_inc;
    logic [CNT_W:0]   drain_inc;

    assign active   = wd_is_active(state);
    assign in_run   = (state == WD_RUN);
    assign in_drain = (state == WD_DRAIN);

    assign cycle_inc = {1'b0, cycle}     + (CNT_W + 1)'(1);
    assign idle_inc  = {1'b0, idle_cnt}  + (CNT_W + 1)'(1);
    assign drain_inc = {1'b0, drain_cnt} + (CNT_W + 1)'(1);

    assign global_to = active && (global_timeout_cfg != '0) &&
                       (cycle_inc == {1'b0, global_timeout_cfg});
    assign retire_to = in_run && (timeout_cfg != '0) && !retire_valid &&
                       (idle_inc == {1'b0, timeout_cfg});
    assign drain_to  = DRAIN_LIMIT_FITS && in_drain && (outstanding != 8'd0) &&
                       (drain_inc == DRAIN_LIMIT_W);

    t1_sat_counter #(.W(CNT_W)) u_cycle (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (active),
        .count (cycle)
    );

    t1_sat_counter #(.W(CNT_W)) u_retired (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (active && retire_valid),
        .count (retired)
    );

    t1_sat_counter #(.W(CNT_W)) u_idle (
        .clock (clock),
        .reset (reset),
        .clr   (in_run && retire_valid),
        .en    (in_run && !retire_valid),
        .count (idle_cnt)
    );

    // Held at zero throughout RUN so DRAIN always starts counting from 0.
    t1_sat_counter #(.W(CNT_W)) u_drain (
        .clock (clock),
        .reset (reset),
        .clr   (in_run),
        .en    (in_drain),
        .count (drain_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= WD_RUN;
            status <= ST_RUN;
        end else begin
            state  <= state_nxt;
            status <= status_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        case (state)
            WD_RUN: begin
                if (global_to) begin
                    state_nxt  = WD_FAIL;
                    status_nxt = ST_GLOBAL_TO;
                end else if (retire_to) begin
                    state_nxt  = WD_FAIL;
                    status_nxt = ST_RETIRE_TO;
                end else if (finish_req) begin
                    state_nxt  = WD_DRAIN;
                end
            end
            WD_DRAIN: begin
                if (global_to) begin
                    state_nxt  = WD_FAIL;
                    status_nxt = ST_GLOBAL_TO;
                end else if (drain_to) begin
                    state_nxt  = WD_FAIL;
                    status_nxt = ST_DRAIN_TO;
                end else if (outstanding == 8'd0) begin
                    state_nxt  = WD_DONE;
                    status_nxt = ST_OK;
                end
            end
            default: begin
                state_nxt  = state;
                status_nxt = status;
            end
        endcase
    end

endmodule
